// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-buffer entry layout.
// An entry is {error, data}, with the parity bit carried in data[7].
package uart_pkg;
  localparam int UART_DATA_W    = 8;
  localparam int UART_ERR_CNT_W = 8;
  localparam int RXBUF_DEPTH    = 16;

  typedef struct packed {
    logic                   error;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

  localparam int RX_ENTRY_W = $bits(rx_entry_t);
endpackage

// File: rtl/uart_rx_buffer_if.sv
// Bundle between the UART receiver, the receive buffer and the consumer.
// Handshake: a frame is offered by the rising edge of rx_ready. The consumer
// sees the head entry whenever empty=0, and a pop happens on a clock edge with
// rd_en=1 and empty=0. rd_en while empty is ignored.
interface uart_rx_buffer_if
  import uart_pkg::*;
#(
    parameter int DATA_W    = UART_DATA_W,
    parameter int ADDR_W    = $clog2(RXBUF_DEPTH),
    parameter int ERR_CNT_W = UART_ERR_CNT_W
);
    logic [DATA_W-1:0]    rx_data;
    logic                 rx_ready;
    logic                 rx_error;
    logic                 rd_en;
    logic [DATA_W-1:0]    rd_data;
    logic                 rd_error;
    logic                 empty;
    logic                 full;
    logic [ADDR_W:0]      count;
    logic                 overflow;
    logic                 clr_overflow;
    logic [ERR_CNT_W-1:0] err_count;

    modport slave (
        input  rx_data, rx_ready, rx_error, rd_en, clr_overflow,
        output rd_data, rd_error, empty, full, count, overflow, err_count
    );

    modport master (
        output rx_data, rx_ready, rx_error, rd_en, clr_overflow,
        input  rd_data, rd_error, empty, full, count, overflow, err_count
    );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock first-word-fall-through FIFO with occupancy outputs.
// Write requests while full are accepted only if a pop happens on the same edge.
module sync_fifo_fwft #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
);
    localparam int CNT_W = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == CNT_W'(DEPTH));
        pop      = rd_en & ~empty;
        push     = wr_en & (~full | pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        rd_data = empty ? '0 : mem_q[rd_ptr_q];
        count   = count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left out of reset; the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side buffer: captures a frame on each rising edge of rx_ready, queues
// {error, data} in a FWFT FIFO, and tracks overflow and parity-error counts.
module uart_rx_buffer
  import uart_pkg::*;
#(
    parameter int DEPTH     = RXBUF_DEPTH,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int DATA_W    = UART_DATA_W,
    parameter int ERR_CNT_W = UART_ERR_CNT_W
) (
    input  logic             sysclk,
    input  logic             reset,
    uart_rx_buffer_if.slave  bus
);
    logic                 ready_q, ready_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 cap, pop, drop;
    logic [DATA_W:0]      wr_entry, rd_entry;
    logic                 fifo_empty, fifo_full;
    logic [ADDR_W:0]      fifo_count;

    always_comb begin
        ready_d     = bus.rx_ready;
        cap         = bus.rx_ready & ~ready_q;
        pop         = bus.rd_en & ~fifo_empty;
        drop        = cap & fifo_full & ~pop;
        wr_entry    = {bus.rx_error, bus.rx_data};
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        // Set beats clear when both land on the same edge.
        if (bus.clr_overflow) overflow_d = 1'b0;
        if (drop)             overflow_d = 1'b1;
        // Dropped frames still count toward parity errors.
        if (cap && bus.rx_error && (err_count_q != '1))
            err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    // ready_q resets high so a level already high at reset release is ignored.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ready_q     <= 1'b1;
            overflow_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            ready_q     <= ready_d;
            overflow_q  <= overflow_d;
            err_count_q <= err_count_d;
        end
    end

    sync_fifo_fwft #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (DATA_W + 1)
    ) u_fifo (
        .clk     (sysclk),
        .rst     (reset),
        .wr_en   (cap),
        .wr_data (wr_entry),
        .rd_en   (bus.rd_en),
        .rd_data (rd_entry),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bus.rd_data   = rd_entry[DATA_W-1:0];
    assign bus.rd_error  = rd_entry[DATA_W];
    assign bus.empty     = fifo_empty;
    assign bus.full      = fifo_full;
    assign bus.count     = fifo_count;
    assign bus.overflow  = overflow_q;
    assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: frames are modelled as receiver
// ready pulses, expected entries are queued and compared on every pop.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = RXBUF_DEPTH;
  localparam int W     = RX_ENTRY_W;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  uart_rx_buffer_if bus ();

  uart_rx_buffer dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  // scoreboard and reference model state
  logic [W-1:0] exp_q[$];
  int           model_cnt = 0;
  int           model_err = 0;
  logic         model_ovf = 1'b0;
  int           n_checks  = 0;
  int           n_pass    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge sysclk);
  endtask

  // Model of one capture edge; popping says a real pop lands on the same edge.
  task automatic model_capture(input logic [7:0] d, input logic e, input bit popping);
    if (e && model_err < 255) model_err++;
    if (model_cnt < DEPTH || popping) begin
      exp_q.push_back({e, d});
      model_cnt++;
    end else begin
      model_ovf = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic e, input int hold);
    bus.rx_data  = d;
    bus.rx_error = e;
    bus.rx_ready = 1'b1;
    model_capture(d, e, 1'b0);
    repeat (hold) tick();
    bus.rx_ready = 1'b0;
    tick();
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] exp;
    check({tag, "_nonempty"}, 32'(bus.empty), 32'(0));
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(1), 32'(0));
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, 32'(bus.rd_data), 32'(exp[7:0]));
      check({tag, "_err"}, 32'(bus.rd_error), 32'(exp[8]));
      model_cnt--;
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'(model_cnt));
    check({tag, "_empty"}, 32'(bus.empty), 32'(model_cnt == 0));
    check({tag, "_full"}, 32'(bus.full), 32'(model_cnt == DEPTH));
    check({tag, "_ovf"}, 32'(bus.overflow), 32'(model_ovf));
    check({tag, "_errcnt"}, 32'(bus.err_count), 32'(model_err));
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 4 * DEPTH) begin
      pop_check(tag);
      guard++;
    end
    check({tag, "_drained"}, 32'(bus.empty), 32'(1));
  endtask

  initial begin
    string hello;
    logic [7:0] b;
    bus.rx_data      = '0;
    bus.rx_error     = 1'b0;
    bus.rx_ready     = 1'b1;
    bus.rd_en        = 1'b0;
    bus.clr_overflow = 1'b0;

    // 1: ready held high across reset release
    repeat (3) tick();
    reset = 1'b0;
    repeat (3) tick();
    check_status("t1");
    check("t1_rd_data_zero", 32'(bus.rd_data), 32'(0));
    bus.rx_ready = 1'b0;
    tick();

    // 2: single long ready pulse
    bus.rx_data  = 8'h48;
    bus.rx_error = 1'b0;
    bus.rx_ready = 1'b1;
    model_capture(8'h48, 1'b0, 1'b0);
    tick();
    check("t2_empty_next", 32'(bus.empty), 32'(0));
    check("t2_rd_data_next", 32'(bus.rd_data), 32'(8'h48));
    repeat (19) tick();
    bus.rx_ready = 1'b0;
    tick();
    check_status("t2");
    pop_check("t2_pop");
    check_status("t2_after");

    // 3: parity error in the middle frame
    send_frame(8'h31, 1'b0, 2);
    send_frame(8'h32, 1'b1, 3);
    send_frame(8'h33, 1'b0, 1);
    check_status("t3");
    drain("t3_pop");

    // 4: fill, overflow, drain, clear
    for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b0, 2);
    check_status("t4_full");
    send_frame(8'hAA, 1'b0, 2);
    check_status("t4_ovf");
    drain("t4_pop");
    check("t4_ovf_sticky", 32'(bus.overflow), 32'(1));
    bus.clr_overflow = 1'b1;
    model_ovf = 1'b0;
    tick();
    bus.clr_overflow = 1'b0;
    check_status("t4_clr");

    // 5a: full with capture and pop on the same edge
    for (int i = 0; i < DEPTH; i++) send_frame(8'(8'h20 + i), 1'b0, 1);
    check("t5_head", 32'(bus.rd_data), 32'(exp_q[0][7:0]));
    void'(exp_q.pop_front());
    model_cnt--;
    bus.rx_data  = 8'h55;
    bus.rx_error = 1'b0;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    model_capture(8'h55, 1'b0, 1'b1);
    tick();
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    check_status("t5_full_cap_pop");
    tick();
    drain("t5_pop");

    // 5b: empty with capture and rd_en on the same edge
    bus.rx_data  = 8'h66;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    model_capture(8'h66, 1'b0, 1'b0);
    tick();
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    check_status("t5_empty_cap_rd");
    tick();
    drain("t5b_pop");

    // 6: text stream with even parity in bit 7, irregular pacing
    hello = "Hello, World!";
    for (int i = 0; i < hello.len(); i++) begin
      b = hello[i];
      b[7] = ^b[6:0];
      send_frame(b, 1'b0, $urandom_range(1, 8));
      repeat ($urandom_range(0, 4)) tick();
    end
    check_status("t6");
    drain("t6_pop");

    // 7: random traffic with interleaved pops
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) pop_check("t7_pop");
    end
    check_status("t7");
    drain("t7_drain");

    // 8: error counter saturation with overflow
    for (int i = 0; i < 260; i++) send_frame(8'(i), 1'b1, 1);
    check_status("t8_sat");

    // 9: reset mid-operation discards everything, including a concurrent cap/pop
    bus.rx_data  = 8'h77;
    bus.rx_ready = 1'b1;
    bus.rd_en    = 1'b1;
    reset        = 1'b1;
    tick();
    reset        = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rx_ready = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    model_err = 0;
    model_ovf = 1'b0;
    check_status("t9_reset");
    check("t9_rd_data_zero", 32'(bus.rd_data), 32'(0));
    tick();
    send_frame(8'h5A, 1'b0, 1);
    check_status("t9_after");
    drain("t9_pop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
